// File: rtl/sched_ucode_if.sv
// Handshake and programming bundle between the top-level controller and the
// microcoded datapath.
interface sched_ucode_if #(
    parameter int W     = 32,
    parameter int NIN   = 6,
    parameter int NREG  = 8,
    parameter int NSTEP = 16
);
    localparam int SW = $clog2(NIN + NREG);
    localparam int RW = $clog2(NREG);
    localparam int PW = $clog2(NSTEP);
    localparam int IW = 5 + 2 * SW + RW;

    logic [NIN*W-1:0] in_flat;
    logic             start;
    logic             prog_we;
    logic [PW-1:0]    prog_addr;
    logic [IW-1:0]    prog_data;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic             dz;

    modport master (
        output in_flat, start, prog_we, prog_addr, prog_data,
        input  busy, done, result, dz
    );

    modport slave (
        input  in_flat, start, prog_we, prog_addr, prog_data,
        output busy, done, result, dz
    );
endinterface

// File: rtl/sched_ucode_datapath.sv
// Microcode-driven ALU / MUL-DIV / LOGIC datapath: runs a loaded schedule once
// per start, with an iterative restoring divider for DIV/REM.
module sched_ucode_datapath #(
    parameter int W     = 32,
    parameter int NIN   = 6,
    parameter int NREG  = 8,
    parameter int NSTEP = 16
) (
    input  logic          clk,
    input  logic          rst,
    sched_ucode_if.slave  bus
);
    localparam int SW = $clog2(NIN + NREG);
    localparam int RW = $clog2(NREG);
    localparam int PW = $clog2(NSTEP);
    localparam int IW = 5 + 2 * SW + RW;
    localparam int CW = $clog2(W);

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_MUL = 2'd1;
    localparam logic [1:0] UNIT_LOG = 2'd2;
    localparam logic [1:0] UNIT_NOP = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, DIVW} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cstore [NSTEP];
    logic [W-1:0]    inp    [NIN];
    logic [W-1:0]    regs   [NREG];
    logic [PW-1:0]   pc;
    logic            busy_q, done_q, dz_q;
    logic [W-1:0]    result_q;
    logic [W-1:0]    div_quo, div_rem, div_den;
    logic [CW-1:0]   div_cnt;

    logic [IW-1:0]   instr;
    logic            i_last;
    logic [1:0]      i_unit, i_op;
    logic [SW-1:0]   i_srca, i_srcb;
    logic [RW-1:0]   i_dst;
    logic [W-1:0]    opa, opb, exec_val;
    logic            is_div;
    logic [W:0]      div_shift, div_trial;
    logic [W-1:0]    quo_n, rem_n;
    logic            wr_en, step_done, fin;
    logic [W-1:0]    wr_val, fin_val;

    function automatic logic [W-1:0] exec_op(input logic [1:0] unit, input logic [1:0] op,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = a;
        case (unit)
            UNIT_ALU: case (op)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = {{(W-1){1'b0}}, (a < b)};
                default: r = a;
            endcase
            UNIT_MUL: if (op == 2'd0) r = a * b;
            UNIT_LOG: case (op)
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = a ^ b;
                default: r = ~a;
            endcase
            default: r = a;
        endcase
        return r;
    endfunction

    assign instr  = cstore[pc];
    assign i_last = instr[IW-1];
    assign i_unit = instr[IW-2 -: 2];
    assign i_op   = instr[IW-4 -: 2];
    assign i_srca = instr[RW+SW +: SW];
    assign i_srcb = instr[RW +: SW];
    assign i_dst  = instr[0 +: RW];

    // Select codes beyond the register file read as zero.
    always_comb begin
        opa = '0;
        opb = '0;
        for (int k = 0; k < NIN; k++) begin
            if (i_srca == SW'(k)) opa = inp[k];
            if (i_srcb == SW'(k)) opb = inp[k];
        end
        for (int k = 0; k < NREG; k++) begin
            if (i_srca == SW'(NIN + k)) opa = regs[k];
            if (i_srcb == SW'(NIN + k)) opb = regs[k];
        end
    end

    assign exec_val = exec_op(i_unit, i_op, opa, opb);
    assign is_div   = (i_unit == UNIT_MUL) && (i_op == 2'd1 || i_op == 2'd2);

    // A zero divisor never fails the trial subtract, which yields all-ones / A.
    assign div_shift = {div_rem, div_quo[W-1]};
    assign div_trial = div_shift - {1'b0, div_den};
    assign quo_n     = {div_quo[W-2:0], ~div_trial[W]};
    assign rem_n     = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_val    = exec_val;
        step_done = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_d = EXEC;
            EXEC: begin
                if (is_div) begin
                    state_d = DIVW;
                end else begin
                    wr_en     = (i_unit != UNIT_NOP);
                    step_done = 1'b1;
                end
            end
            DIVW: begin
                if (div_cnt == CW'(W - 1)) begin
                    wr_en     = 1'b1;
                    wr_val    = (i_op == 2'd2) ? rem_n : quo_n;
                    step_done = 1'b1;
                    state_d   = EXEC;
                end
            end
            default: state_d = IDLE;
        endcase
        fin     = i_last || (pc == PW'(NSTEP - 1));
        fin_val = wr_en ? wr_val : regs[i_dst];
        if (step_done && fin) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Control store deliberately survives reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we && !busy_q) cstore[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            pc       <= '0;
            div_quo  <= '0;
            div_rem  <= '0;
            div_den  <= '0;
            div_cnt  <= '0;
            for (int k = 0; k < NIN; k++)  inp[k]  <= '0;
            for (int k = 0; k < NREG; k++) regs[k] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    for (int k = 0; k < NIN; k++)  inp[k]  <= bus.in_flat[k*W +: W];
                    for (int k = 0; k < NREG; k++) regs[k] <= '0;
                    dz_q   <= 1'b0;
                    pc     <= '0;
                    busy_q <= 1'b1;
                end
                EXEC: if (is_div) begin
                    div_quo <= opa;
                    div_rem <= '0;
                    div_den <= opb;
                    div_cnt <= '0;
                    if (opb == '0) dz_q <= 1'b1;
                end
                DIVW: begin
                    div_quo <= quo_n;
                    div_rem <= rem_n;
                    div_cnt <= div_cnt + 1'b1;
                end
                default: ;
            endcase
            if (wr_en) regs[i_dst] <= wr_val;
            if (step_done) begin
                if (fin) begin
                    result_q <= fin_val;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.dz     = dz_q;
endmodule

// File: tb/tb_sched_ucode_datapath.sv
// Directed scoreboard bench for the microcoded datapath: expected result, dz and
// latency are queued at start and checked whenever done pulses.
module tb_sched_ucode_datapath;
    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    sched_ucode_if #(.W(32), .NIN(6), .NREG(8), .NSTEP(16)) bus ();

    sched_ucode_datapath #(.W(32), .NIN(6), .NREG(8), .NSTEP(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] mk(input logic last, input logic [1:0] unit, input logic [1:0] op,
                                       input logic [3:0] a, input logic [3:0] b, input logic [2:0] d);
        return {last, unit, op, a, b, d};
    endfunction

    task automatic prog(input int addr, input logic [15:0] data);
        @(negedge clk);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'(addr);
        bus.prog_data = data;
        @(posedge clk);
        #1 bus.prog_we = 1'b0;
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bus.in_flat = '0;
        bus.in_flat[0*W +: W] = a;
        bus.in_flat[1*W +: W] = b;
        bus.in_flat[2*W +: W] = c;
    endtask

    task automatic start_run(input logic [31:0] res, input logic dz, input int lat);
        exp_t e;
        e.res = res;
        e.dz  = dz;
        e.lat = lat;
        @(negedge clk);
        exp_q.push_back(e);
        bus.start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int  gap = 0;
        bit  seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(posedge clk);
            #2;
            if (bus.done) seen = 1;
            else if (!bus.busy) gap++;
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s_timeout: no done within 300 cycles", name);
            exp_q.delete();
        end
        check({name, "_busy_gap"}, 32'(gap), 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic load_divprog();
        prog(0, mk(0, 2'd1, 2'd1, 4'd0, 4'd1, 3'd0));
        prog(1, mk(0, 2'd1, 2'd2, 4'd0, 4'd1, 3'd1));
        prog(2, mk(1, 2'd0, 2'd0, 4'd6, 4'd7, 3'd2));
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: result %h with no run outstanding", bus.result);
            end else begin
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("dz", 32'(bus.dz), 32'(e.dz));
                check("latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.in_flat   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_dz", 32'(bus.dz), 32'd0);

        // Multiply-add: 3*4+5
        prog(0, mk(0, 2'd1, 2'd0, 4'd0, 4'd1, 3'd0));
        prog(1, mk(1, 2'd0, 2'd0, 4'd6, 4'd2, 3'd1));
        set_in(32'd3, 32'd4, 32'd5);
        start_run(32'd17, 1'b0, 2);
        wait_done("muladd");

        // 100/7 + 100%7
        load_divprog();
        set_in(32'd100, 32'd7, 32'd0);
        start_run(32'd16, 1'b0, 67);
        wait_done("divrem");

        // Divide by zero: all-ones + 100 wraps to 99
        set_in(32'd100, 32'd0, 32'd0);
        start_run(32'h00000063, 1'b1, 67);
        wait_done("divzero");
        set_in(32'd100, 32'd7, 32'd0);
        start_run(32'd16, 1'b0, 67);
        wait_done("dzclear");

        // Reset during DIVW, with dz already set by the zero divisor
        set_in(32'd100, 32'd0, 32'd0);
        start_run(32'd0, 1'b0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_dz", 32'(bus.dz), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        set_in(32'd100, 32'd7, 32'd0);
        start_run(32'd16, 1'b0, 67);
        wait_done("rerun");

        // Protocol: start, program write and input change during busy are ignored
        start_run(32'd16, 1'b0, 67);
        repeat (5) @(negedge clk);
        set_in(32'd50, 32'd3, 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        prog(0, mk(0, 2'd0, 2'd3, 4'd2, 4'd0, 3'd0));
        wait_done("protocol");
        repeat (80) @(negedge clk);
        check("done_pulses", 32'(done_cnt), 32'd6);
        set_in(32'd100, 32'd7, 32'd5);
        start_run(32'd16, 1'b0, 67);
        wait_done("step0_intact");

        // Sixteen steps, no last bit: finish at the final slot, 0-1 wraps
        for (int s = 0; s < 15; s++) prog(s, mk(0, 2'd3, 2'd0, 4'd0, 4'd0, 3'd0));
        prog(15, mk(0, 2'd0, 2'd1, 4'd0, 4'd1, 3'd3));
        set_in(32'd0, 32'd1, 32'd0);
        start_run(32'hFFFFFFFF, 1'b0, 16);
        wait_done("wrap");

        repeat (5) @(negedge clk);
        check("total_done", 32'(done_cnt), 32'd8);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
